// File: rtl/regfile_dump_reader.sv
// Debug reader that walks the architectural registers through an async read port
// and streams each value with its index on a valid/ready interface.
module regfile_dump_reader #(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_SEND,
    S_FIN
  } state_t;

  localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic              last_q, last_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    index_d = index_q;
    last_d  = last_q;

    unique case (state_q)
      S_IDLE: begin
        // abort outranks start even while idle, so a coincident pair starts nothing
        if (start && !abort) begin
          idx_d   = IDX_FIRST;
          state_d = S_READ;
        end
      end
      S_READ: begin
        data_d  = rd_data;
        index_d = idx_q;
        last_d  = (idx_q == IDX_LAST);
        state_d = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_READ;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // abort discards any capture or handshake of this cycle
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      idx_d   = idx_q;
      data_d  = data_q;
      index_d = index_q;
      last_d  = last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= IDX_FIRST;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      index_q <= index_d;
      last_q  <= last_d;
    end
  end

  assign rd_addr   = idx_q;
  assign out_valid = (state_q == S_SEND);
  assign out_data  = data_q;
  assign out_index = index_q;
  assign out_last  = last_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN) && !abort;

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
    (out_valid && !out_ready && !abort) |=>
      (out_valid && $stable(out_data) && $stable(out_index) && $stable(out_last)));

  a_done_excl: assert property (@(posedge clk) disable iff (!rst)
    done |-> !out_valid);

  a_idx_range: assert property (@(posedge clk) disable iff (!rst)
    (idx_q >= IDX_FIRST) && (idx_q <= IDX_LAST));

endmodule
